simon_decrypt_iter: RTL and testbench



---
 rtl/simon_pkg.sv | 20 ++
 rtl/simon_decrypt_iter_if.sv | 14 +
 rtl/simon_keyexp.sv | 53 +++++
 rtl/simon_decrypt_iter.sv | 83 ++++++++
 tb/tb_simon_decrypt_iter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants, types and round helpers, used by both the
// encrypt pipeline and the iterative decryptor.
package simon_pkg;
    localparam int SIMON_N            = 16;
    localparam int SIMON_ROUNDS       = 32;
    localparam int SIMON_KEYEXP_STEPS = 28;
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [15:0] C_KEY = 16'hFFFC;

    typedef logic [SIMON_N-1:0] word_t;
    typedef enum logic [1:0] {KEYEXP, IDLE, RUN, DONE} state_t;

    function automatic word_t rotl(word_t v, int unsigned j);
        return word_t'((v << j) | (v >> (SIMON_N - j)));
    endfunction

    function automatic word_t f_simon(word_t v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction
endpackage

// File: rtl/simon_decrypt_iter_if.sv
// Ciphertext-in / plaintext-out valid-ready bus of the decryptor.
interface simon_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/simon_keyexp.sv
// Round-key register file for Simon 32/64: seeded with the key words on reset,
// then expanded one key per enabled cycle; exposes a combinational read port.
module simon_keyexp
    import simon_pkg::*;
#(
    parameter logic [63:0] KEY = 64'h1918111009080100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] rd_idx,
    output word_t      rd_key,
    output logic       key_done
);
    word_t      rk_q [32];
    word_t      rk_d [32];
    logic [4:0] i_q, i_d;
    logic [4:0] i1, i3, i4;
    logic [5:0] zi;
    word_t      tmp;

    always_comb begin
        rk_d = rk_q;
        i_d  = i_q;
        i1   = i_q + 5'd1;
        i3   = i_q + 5'd3;
        i4   = i_q + 5'd4;
        zi   = 6'd61 - {1'b0, i_q};
        tmp  = rotl(rk_q[i3], 13) ^ rk_q[i1];
        tmp  = tmp ^ rotl(tmp, 15);
        if (en) begin
            rk_d[i4] = C_KEY ^ {15'b0, Z0[zi]} ^ rk_q[i_q] ^ tmp;
            if (i_q != 5'(SIMON_KEYEXP_STEPS - 1)) i_d = i1;
        end
    end

    // High during the cycle whose edge writes the last round key.
    assign key_done = en && (i_q == 5'(SIMON_KEYEXP_STEPS - 1));
    assign rd_key   = rk_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q      <= '0;
            rk_q[0]  <= KEY[15:0];
            rk_q[1]  <= KEY[31:16];
            rk_q[2]  <= KEY[47:32];
            rk_q[3]  <= KEY[63:48];
        end else begin
            i_q  <= i_d;
            rk_q <= rk_d;
        end
    end
endmodule

// File: rtl/simon_decrypt_iter.sv
// Iterative Simon 32/64 decryptor: key expansion after reset, then one
// inverse round per clock, 32 rounds per block, valid/ready on both sides.
module simon_decrypt_iter
    import simon_pkg::*;
#(
    parameter logic [63:0] KEY    = 64'h1918111009080100,
    parameter int          ROUNDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_decrypt_iter_if.slave  bus
);
    generate
        if (ROUNDS != SIMON_ROUNDS) begin : g_bad_rounds
            $error("simon_decrypt_iter supports only ROUNDS = 32");
        end
    endgenerate

    state_t      state_q, state_d;
    word_t       x_q, x_d, y_q, y_d;
    logic [4:0]  rc_q, rc_d;
    logic [31:0] out_q, out_d;
    word_t       rk;
    logic        key_done;

    simon_keyexp #(.KEY(KEY)) u_keyexp (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == KEYEXP),
        .rd_idx   (rc_q),
        .rd_key   (rk),
        .key_done (key_done)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rc_d    = rc_q;
        out_d   = out_q;
        case (state_q)
            KEYEXP: if (key_done) state_d = IDLE;
            IDLE: if (bus.in_valid) begin
                x_d     = bus.in_data[31:16];
                y_d     = bus.in_data[15:0];
                rc_d    = 5'(SIMON_ROUNDS - 1);
                state_d = RUN;
            end
            RUN: begin
                // Inverse round: keys consumed from k[31] down to k[0].
                x_d  = y_q;
                y_d  = x_q ^ f_simon(y_q) ^ rk;
                rc_d = rc_q - 5'd1;
                if (rc_q == 5'd0) begin
                    out_d   = {x_d, y_d};
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = KEYEXP;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KEYEXP;
            x_q     <= '0;
            y_q     <= '0;
            rc_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rc_q    <= rc_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_simon_decrypt_iter.sv
// Directed and round-trip bench for simon_decrypt_iter; ciphertexts for the
// round trip come from a forward Simon 32/64 encryption model.
module tb_simon_decrypt_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simon_decrypt_iter_if bus();

    simon_decrypt_iter #(.KEY(64'h1918111009080100), .ROUNDS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_out = 0;

    localparam logic [61:0] ZB = 62'b11111010001001010110000111001101111101000100101011000011100110;
    logic [15:0] mk [32];

    typedef struct {
        logic [31:0] ct;
        logic [31:0] pt;
        int          stall;
        bit          noise;
        bit          model;
    } vec_t;
    vec_t vt [6];

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)   n_acc <= n_acc + 1;
        if (!rst && bus.out_valid && bus.out_ready) n_out <= n_out + 1;
    end

    function automatic logic [15:0] rl(logic [15:0] v, int s);
        return 16'((v << s) | (v >> (16 - s)));
    endfunction

    function automatic logic [31:0] enc(logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ mk[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n, output bit saw_ov);
        n = 0;
        saw_ov = 1'b0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
            if (bus.out_valid) saw_ov = 1'b1;
        end
    endtask

    task automatic run_block(input logic [31:0] ct, input logic [31:0] exp,
                             input int stall, input bit noise, output time t_acc);
        int n;
        int lat;
        bus.in_data  = ct;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        step();
        t_acc = $time;
        bus.in_valid = 1'b0;
        chk("in_ready_drop_after_accept", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (noise) begin
                bus.in_data  = $urandom;
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("out_valid_latency", 32'(lat), 32'd32);
        chk("out_data", bus.out_data, exp);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out_data", bus.out_data, exp);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_out_data_hold", bus.out_data, exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        bit   saw_ov;
        time  t1, t2;
        logic [15:0] t;
        logic [31:0] pt, ct;

        mk[0] = 16'h0100; mk[1] = 16'h0908; mk[2] = 16'h1110; mk[3] = 16'h1918;
        for (int i = 0; i < 28; i++) begin
            t = rl(mk[i+3], 13) ^ mk[i+1];
            t = t ^ rl(t, 15);
            mk[i+4] = ~mk[i] ^ 16'h0003 ^ {15'b0, ZB[61-i]} ^ t;
        end

        vt[0] = '{32'hC69BE9BB, 32'h65656877, 0,  1'b0, 1'b0};
        vt[1] = '{32'hC69BE9BB, 32'h65656877, 10, 1'b0, 1'b0};
        vt[2] = '{32'hC69BE9BB, 32'h65656877, 0,  1'b1, 1'b0};
        vt[3] = '{32'h0,        32'h00000000, 1,  1'b0, 1'b1};
        vt[4] = '{32'h0,        32'hFFFFFFFF, 0,  1'b0, 1'b1};
        vt[5] = '{32'h0,        32'h80000001, 3,  1'b1, 1'b1};

        // Reset with in_valid already asserted.
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hC69BE9BB;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", bus.out_data, 32'h0);
        rst = 1'b0;
        wait_ready(n, saw_ov);
        chk("keyexp_cycles", 32'(n), 32'd28);
        chk("keyexp_no_out_valid", 32'(saw_ov), 32'd0);

        for (int v = 0; v < 6; v++) begin
            ct = vt[v].model ? enc(vt[v].pt) : vt[v].ct;
            run_block(ct, vt[v].pt, vt[v].stall, vt[v].noise, t1);
        end

        // Back-to-back blocks with no output stall: one accept per 34 cycles.
        run_block(32'hC69BE9BB, 32'h65656877, 0, 1'b0, t1);
        run_block(32'hC69BE9BB, 32'h65656877, 0, 1'b0, t2);
        chk("throughput_period", 32'(t2 - t1), 32'd340);

        // Reset in the middle of RUN: the block is dropped, key expansion reruns.
        bus.in_data  = 32'hC69BE9BB;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        saw_ov = 1'b0;
        for (int r = 0; r < 15; r++) begin
            step();
            if (bus.out_valid) saw_ov = 1'b1;
        end
        chk("midrun_no_out_valid_before_rst", 32'(saw_ov), 32'd0);
        rst = 1'b1;
        step();
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_out_data", bus.out_data, 32'h0);
        rst = 1'b0;
        wait_ready(n, saw_ov);
        chk("midrun_keyexp_cycles", 32'(n), 32'd28);
        chk("midrun_no_out_valid", 32'(saw_ov), 32'd0);
        run_block(32'hC69BE9BB, 32'h65656877, 0, 1'b0, t1);

        for (int k = 0; k < 1000; k++) begin
            pt = $urandom;
            run_block(enc(pt), pt, int'($urandom_range(0, 2)), 1'b0, t1);
        end

        step();
        chk("one_output_per_kept_block", 32'(n_out), 32'(n_acc - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
